// File: rtl/countdown_timer_if.sv
// rtl/countdown_timer_if.sv - control/status bundle between a timer client and countdown_timer
interface countdown_timer_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output load, load_val, start, pause,
    input  count, busy, done
  );

  modport slave (
    input  load, load_val, start, pause,
    output count, busy, done
  );
endinterface

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable start/pause down-counter with one-cycle done pulse
// Optional periodic reload on reaching zero when AUTO_RELOAD_EN is defined.
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  countdown_timer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             restart;

`ifdef AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
  assign restart = (reload_q != '0);
`else
  assign restart = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
`ifdef AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (bus.load) begin
      count_d = bus.load_val;
      state_d = S_IDLE;
`ifdef AUTO_RELOAD_EN
      reload_d = bus.load_val;
`endif
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            if (count_q != '0) begin
              state_d = S_RUN;
            end else begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end
        end
        S_RUN: begin
          if (bus.pause) begin
            state_d = S_PAUSED;
          end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
            if (count_q == WIDTH'(1)) begin
              done_d = 1'b1;
              if (!restart) state_d = S_DONE;
            end
          end else begin
            // Only reachable with auto-reload: the cycle after the zero pulse restarts the period.
`ifdef AUTO_RELOAD_EN
            count_d = reload_q;
`else
            state_d = S_DONE;
`endif
          end
        end
        S_PAUSED: begin
          if (!bus.pause && bus.start) state_d = S_RUN;
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d == S_RUN) || (state_d == S_PAUSED);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable, startable/pausable down-counter; the stage directly upstream of ZeroDetect.
- Its Count output drives ZeroDetect's In bus. Count reaching zero is also flagged locally by the Done pulse.
- Single clock domain; pure synchronous logic, with an explicit FSM for control.

Parameters:
- WIDTH, 4, counter width; matches ZeroDetect's 4-bit In.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clk.
- Load  input  1  load request; captures LoadVal.
- LoadVal  input  WIDTH  value to load into Count.
- Start  input  1  start or resume counting.
- Pause  input  1  freeze counting while running.
- Count  output  WIDTH  registered counter value; feeds ZeroDetect In.
- Busy  output  1  high in RUN and PAUSED states.
- Done  output  1  one-cycle pulse when Count becomes 0 through counting.

Behaviour:
- All outputs are registered. No combinational path from any input to any output.
- Reset: synchronous, active-high. Next edge sets state=IDLE, Count=0, Busy=0, Done=0, reload register=0. Reset mid-run aborts the run immediately; no Done pulse is produced.
- States: IDLE, RUN, PAUSED, DONE. Encoding is free; 2-bit binary is acceptable.
- Priority per edge: Reset > Load > Pause > Start.
- Load, in any state:
  - Count<=LoadVal, state->IDLE, Done=0.
  - A Load while in RUN aborts the run with no Done pulse.
- IDLE / DONE:
  - Start with Count!=0 -> RUN. Count is not decremented on this edge.
  - Start with Count==0 -> DONE, Done=1 for one cycle.
  - Pause is ignored.
- RUN:
  - Each edge, Count<=Count-1.
  - On the edge where Count goes 1->0: state->DONE, Done=1 in the following cycle, aligned with Count==0.
  - Pause -> PAUSED; Count holds and does not decrement on that edge.
  - Start is ignored.
- PAUSED:
  - Count holds.
  - Start -> RUN, no decrement on that edge.
  - Pause alone keeps the state.
  - Start+Pause together: Pause wins, stay PAUSED.
- Latency: Start sampled at edge 0 with Count=L>0 gives Count=L-k after edge k. Count=0 and Done=1 after edge L.
- Done is never high for two consecutive cycles, except for repeated Start with Count==0 in IDLE/DONE, which gives one pulse per Start edge.
- Busy = (state==RUN || state==PAUSED), registered with the state.
- Count never wraps below 0; the decrement is only performed when Count!=0.

Optional Feature:
- Macro: AUTO_RELOAD_EN.
- Defined:
  - A reload register captures LoadVal on every Load.
  - In RUN, when Count==0 with Done=1, the FSM stays in RUN instead of entering DONE.
  - The next edge sets Count<=reload value, giving a periodic sequence L, L-1, ..., 1, 0, L, ... with period L+1 and one Done pulse per period.
  - If the reload value is 0, the FSM goes to DONE as in the base behaviour.
  - Pause and Load apply as in the base behaviour.
- Undefined:
  - No reload register is present.
  - The FSM always enters DONE when Count reaches 0.

Test Plan:
- Reset then idle: Reset=1 for 2 cycles, then all inputs 0 for 5 cycles -> Count=0, Busy=0, Done=0 throughout.
- Basic count: Load LoadVal=3, then Start for one cycle -> Count 3,2,1,0 on successive edges; Busy=1 for 3 cycles; Done=1 exactly in the cycle Count=0; DONE state holds Count=0.
- Pause/resume: LoadVal=5, Start, Pause after Count=3 for 4 cycles, then Start -> Count stays 3 during the pause, then 2,1,0; one Done pulse; Busy=1 throughout the pause.
- Priority: in RUN at Count=4, assert Load (LoadVal=9) together with Pause and Start -> Count=9, state IDLE, Busy=0, no Done. Separately, Reset together with Load -> Count=0.
- Zero start: after reset, Count=0 and Start for 1 cycle -> Done=1 for one cycle, Busy stays 0, Count stays 0.
- AUTO_RELOAD_EN build: LoadVal=2, Start, run 9 cycles -> Count 2,1,0,2,1,0,2,1,0; Done high on each 0; Busy stays 1.
